// File: rtl/redirect_pkg.sv
// Shared definitions for the ID-stage hazard/redirect logic: operand select
// codes and the shadow-slot record tracked for EX, MEM and WB.
package redirect_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             load;
    } slot_t;

endpackage

// File: rtl/hazard_slot_reg.sv
// One shadow pipeline slot: async clear, advance enable and bubble insertion.
module hazard_slot_reg
    import redirect_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/hazard_redirect_unit.sv
// Load-use stall and forwarding-select generation for the ID/EX register,
// driven from a private shadow pipeline of destination tags.
module hazard_redirect_unit #(
    parameter logic [redirect_pkg::REG_W-1:0] ZERO_REG = redirect_pkg::ZERO_REG,
    parameter int                             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCen,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memload,
    output logic             stall,
    output logic [1:0]       rfd1sel,
    output logic [1:0]       rfd2sel,
    output logic [CNT_W-1:0] stall_count
);
    import redirect_pkg::*;

    slot_t ex_q, mem_q, wb_unused;
    slot_t ex_d;
    logic  ex_bubble;
    logic  m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
    logic  stall_raw;

    function automatic logic hit(input slot_t s, input logic [4:0] src, input logic used,
                                 input logic valid);
        return s.valid & s.regwrite & (s.rd == src) & (src != ZERO_REG) & used & valid;
    endfunction

    assign ex_d      = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, load: id_memload};
    assign ex_bubble = stall | id_flush | ~id_valid;

    hazard_slot_reg u_ex (
        .clk(clk), .rst_n(rst_n), .en(PCen), .bubble(ex_bubble), .d(ex_d), .q(ex_q)
    );
    hazard_slot_reg u_mem (
        .clk(clk), .rst_n(rst_n), .en(PCen), .bubble(1'b0), .d(ex_q), .q(mem_q)
    );
    // WB is tracked but never bypassed: the register file writes before it reads.
    hazard_slot_reg u_wb (
        .clk(clk), .rst_n(rst_n), .en(PCen), .bubble(1'b0), .d(mem_q), .q(wb_unused)
    );

    assign m_ex_rs  = hit(ex_q,  id_rs, id_rs_used, id_valid);
    assign m_ex_rt  = hit(ex_q,  id_rt, id_rt_used, id_valid);
    assign m_mem_rs = hit(mem_q, id_rs, id_rs_used, id_valid);
    assign m_mem_rt = hit(mem_q, id_rt, id_rt_used, id_valid);

    assign stall_raw = ex_q.load & (m_ex_rs | m_ex_rt);
    assign stall     = stall_raw & ~id_flush;

    // Youngest producer wins; a load in EX cannot forward, so it falls through.
    always_comb begin
        rfd1sel = SEL_RF;
        rfd2sel = SEL_RF;
        if (!stall) begin
            if (m_ex_rs && !ex_q.load) rfd1sel = SEL_EXMEM;
            else if (m_mem_rs)         rfd1sel = SEL_MEMWB;
            if (m_ex_rt && !ex_q.load) rfd2sel = SEL_EXMEM;
            else if (m_mem_rt)         rfd2sel = SEL_MEMWB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && PCen && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_redirect_unit.sv
// Directed bench for hazard_redirect_unit: a per-cycle vector table plus
// hand sequences for reset mid-stall and counter saturation.
module tb_hazard_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcen, id_valid, id_flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_rs_used, id_rt_used, id_regwrite, id_memload;
    logic        stall;
    logic [1:0]  rfd1sel, rfd2sel;
    logic [15:0] stall_count;
    logic        stall_s;
    logic [1:0]  rfd1sel_s, rfd2sel_s;
    logic [3:0]  stall_count_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_redirect_unit #(.ZERO_REG(5'd0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .PCen(pcen), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memload(id_memload),
        .stall(stall), .rfd1sel(rfd1sel), .rfd2sel(rfd2sel), .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    hazard_redirect_unit #(.ZERO_REG(5'd0), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .PCen(pcen), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memload(id_memload),
        .stall(stall_s), .rfd1sel(rfd1sel_s), .rfd2sel(rfd2sel_s), .stall_count(stall_count_s)
    );

    typedef struct {
        logic        pcen, valid, flush;
        logic [4:0]  rs;
        logic        rsu;
        logic [4:0]  rt;
        logic        rtu;
        logic [4:0]  rd;
        logic        rw, ld;
        logic        e_stall;
        logic [1:0]  e_s1, e_s2;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic p, input logic v, input logic f,
                                input logic [4:0] rs, input logic rsu,
                                input logic [4:0] rt, input logic rtu,
                                input logic [4:0] rd, input logic rw, input logic ld,
                                input logic es, input logic [1:0] e1, input logic [1:0] e2,
                                input logic [15:0] ec);
        vec_t r;
        r.pcen = p; r.valid = v; r.flush = f;
        r.rs = rs; r.rsu = rsu; r.rt = rt; r.rtu = rtu;
        r.rd = rd; r.rw = rw; r.ld = ld;
        r.e_stall = es; r.e_s1 = e1; r.e_s2 = e2; r.e_cnt = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic p, input logic v, input logic f,
                         input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu,
                         input logic [4:0] rd, input logic rw, input logic ld);
        pcen = p; id_valid = v; id_flush = f;
        id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd; id_regwrite = rw; id_memload = ld;
    endtask

    initial begin
        //          p  v  f  rs  u  rt  u  rd  rw ld  st s1 s2 cnt
        vecs[0]  = mk(1, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 1,  1, 2,  1, 5,  1, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 5,  1, 3,  1, 6,  1, 0, 0, 1, 0, 0);
        vecs[3]  = mk(1, 1, 0, 5,  1, 6,  1, 7,  0, 0, 0, 2, 1, 0);
        vecs[4]  = mk(1, 1, 0, 5,  1, 7,  1, 0,  0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0,  1, 0,  0, 8,  1, 1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 9,  1, 8,  1, 10, 1, 0, 1, 0, 0, 0);
        vecs[7]  = mk(1, 1, 0, 9,  1, 8,  1, 10, 1, 0, 0, 0, 2, 1);
        vecs[8]  = mk(1, 1, 0, 0,  0, 0,  0, 8,  1, 1, 0, 0, 0, 1);
        vecs[9]  = mk(1, 1, 1, 8,  1, 0,  0, 11, 1, 0, 0, 0, 0, 1);
        vecs[10] = mk(1, 1, 0, 8,  1, 11, 1, 0,  0, 0, 0, 2, 0, 1);
        vecs[11] = mk(1, 1, 0, 0,  0, 0,  0, 0,  1, 1, 0, 0, 0, 1);
        vecs[12] = mk(1, 1, 0, 0,  1, 0,  1, 0,  0, 0, 0, 0, 0, 1);
        vecs[13] = mk(1, 1, 0, 0,  1, 0,  1, 0,  0, 0, 0, 0, 0, 1);
        vecs[14] = mk(1, 1, 0, 0,  0, 0,  0, 12, 1, 1, 0, 0, 0, 1);
        vecs[15] = mk(0, 1, 0, 12, 1, 0,  0, 13, 1, 0, 1, 0, 0, 1);
        vecs[16] = mk(0, 1, 0, 12, 1, 0,  0, 13, 1, 0, 1, 0, 0, 1);
        vecs[17] = mk(0, 1, 0, 12, 1, 0,  0, 13, 1, 0, 1, 0, 0, 1);
        vecs[18] = mk(1, 1, 0, 12, 1, 0,  0, 13, 1, 0, 1, 0, 0, 1);
        vecs[19] = mk(1, 1, 0, 12, 1, 0,  0, 13, 1, 0, 0, 2, 0, 2);
        vecs[20] = mk(1, 0, 0, 13, 1, 0,  0, 0,  0, 0, 0, 0, 0, 2);
        vecs[21] = mk(1, 1, 0, 13, 1, 0,  0, 0,  0, 0, 0, 2, 0, 2);

        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_sel1", 32'(rfd1sel), 0);
        chk("reset_sel2", 32'(rfd2sel), 0);
        chk("reset_cnt", 32'(stall_count), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].pcen, vecs[i].valid, vecs[i].flush, vecs[i].rs, vecs[i].rsu,
                  vecs[i].rt, vecs[i].rtu, vecs[i].rd, vecs[i].rw, vecs[i].ld);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_sel1", i), 32'(rfd1sel), 32'(vecs[i].e_s1));
            chk($sformatf("v%0d_sel2", i), 32'(rfd2sel), 32'(vecs[i].e_s2));
            chk($sformatf("v%0d_cnt", i), 32'(stall_count), 32'(vecs[i].e_cnt));
            @(posedge clk); #1;
        end

        // Reset asserted while a load-use stall is pending.
        drive(1, 1, 0, 0, 0, 0, 0, 8, 1, 1);
        @(posedge clk); #1;
        drive(1, 1, 0, 0, 0, 8, 1, 9, 1, 0);
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_sel2", 32'(rfd2sel), 0);
        chk("midrst_cnt", 32'(stall_count), 0);
        chk("midrst_cnt_sat", 32'(stall_count_s), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_stall", 32'(stall), 0);
        chk("postrst_sel2", 32'(rfd2sel), 0);
        chk("postrst_cnt", 32'(stall_count), 0);
        @(posedge clk); #1;

        // Chain of dependent loads: a stall every other cycle.
        drive(1, 1, 0, 8, 1, 0, 0, 8, 1, 1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            chk($sformatf("chain%0d_stall", i), 32'(stall), (i % 2 == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("chain_cnt16", 32'(stall_count), 20);
        chk("chain_cnt4_sat", 32'(stall_count_s), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_redirect_unit.md
# hazard_redirect_unit

Producer side of the ID/EX pipeline register's control inputs: generates the `stall` request and the operand redirect selects `rfd1sel`/`rfd2sel` that the ID/EX register latches alongside the decoded instruction. It keeps its own shadow pipeline of destination-register tags for the EX, MEM and WB stages. From that shadow pipeline it detects load-use hazards, which cause a one-cycle stall, and RAW hazards that forwarding resolves. It sits beside the decoder in ID and also keeps a saturating stall-cycle counter for performance debug.

## Interface
- `ZERO_REG`, 0: register index that never creates a hazard.
- `CNT_W`, 16: width of the stall counter.

- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `PCen`  in  1  global advance enable; 0 freezes all state
- `id_valid`  in  1  ID holds a real instruction
- `id_flush`  in  1  branch redirect; the current ID instruction enters EX as a bubble
- `id_rs`, `id_rt`  in  5 each  source register indices
- `id_rs_used`, `id_rt_used`  in  1 each  the source is actually read
- `id_rd`  in  5  destination index
- `id_regwrite`  in  1  the instruction writes `id_rd`
- `id_memload`  in  1  the instruction is a load (`dmld`)
- `stall`  out  1  hold PC/IF-ID and insert a bubble into EX
- `rfd1sel`, `rfd2sel`  out  2 each  operand source for rs/rt
- `stall_count`  out  CNT_W  stall cycles since reset

## Operation
- **Shadow slots**: EX, MEM and WB. Each slot holds `{valid, rd, regwrite, load}`.
- **Hazard match**: `match(slot, src)` = `slot.valid & slot.regwrite & slot.rd == src & src != ZERO_REG & src_used & id_valid`.
- **stall** (combinational) = `match(EX, rs) | match(EX, rt)` when `EX.load` = 1. `stall` is forced to 0 when `id_flush` = 1.
- **Select encoding**:
  - 0 = register file. The register file writes in the first half-cycle and reads in the second, so no WB bypass is needed.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB result (ALU or load data).
  - 3 = reserved, never driven.
- **Per-source select**: if `match(EX)` and not `EX.load` → 1; else if `match(MEM)` → 2; else 0. EX has priority over MEM, so the youngest producer wins.
- **Selects during stall**: when `stall` = 1, both selects are forced to 0. The bubble makes them irrelevant.
- **Shift** on a rising edge with `PCen` = 1:
  - WB ← MEM, MEM ← EX.
  - EX ← bubble (`valid` = 0) if `stall | id_flush | ~id_valid`.
  - Otherwise EX ← {1, `id_rd`, `id_regwrite`, `id_memload`}.
- **Freeze**: with `PCen` = 0, the slots and the counter hold their values.
- **stall_count**: increments on each edge with `stall & PCen`. It saturates at all-ones and does not wrap.

## Timing
- **Reset**: `rst_n` low asynchronously clears every slot (`valid` = 0) and `stall_count` = 0. Therefore `stall` = 0 and both selects = 0 while in reset and in the first cycle after release.
- **Zero latency**: `stall` and the selects are combinational from the current ID fields and the slot registers.
- **Load-use stall length**: exactly one cycle.
  - Cycle N: the load is in EX; `stall` = 1.
  - Cycle N+1: the load is in MEM and the bubble is in EX. The stalled consumer, still in ID, now sees `rfd*sel` = 2.
- **Back-to-back dependency** (ALU producer directly ahead of its consumer): no stall; sel = 1 in the consumer's ID cycle.
- **Simultaneous `stall` and `id_flush`**: flush wins. `stall` = 0, EX gets a bubble, and the counter does not increment.
- **`PCen` = 0 during a stall**: `stall` stays 1 and the counter is held. The same hazard is re-evaluated once `PCen` returns to 1.
- **Reset mid-stall**: `stall` drops in the same cycle as `rst_n` falls. Any in-flight hazards are forgotten.

## Structure
- **Shared package `redirect_pkg`**: `SEL_RF` = 0, `SEL_EXMEM` = 1, `SEL_MEMWB` = 2; the slot struct/field widths; `ZERO_REG`.
- **Sub-module `hazard_slot_reg`**: one shadow slot with async active-low clear, enable, and bubble-insert. Instantiated three times.
- **Top level**: the match/priority logic and the counter.

## Test plan
- Reset asserted mid-stream, then released → `stall` = 0, `rfd1sel` = `rfd2sel` = 0, `stall_count` = 0.
- ALU writes r5, then next instruction reads r5 as rs → `rfd1sel` = 1 and `stall` = 0. One cycle later, with an independent instruction in between, a reader of r5 sees `rfd1sel` = 2.
- Load writes r8, then next instruction reads r8 as rt:
  - First cycle: `stall` = 1, `rfd2sel` = 0, and `stall_count` goes 0→1.
  - Next cycle: `stall` = 0, `rfd2sel` = 2.
- Load writes r8, consumer reads r8, `id_flush` = 1 in the same cycle → `stall` = 0, `stall_count` unchanged, EX slot invalid.
- Producer writes r0 and the consumer reads r0 → selects stay 0 and no stall occurs. Separately, `PCen` held 0 for 3 cycles during a load-use → `stall` held at 1 and the counter frozen.
- Force 65,540 load-use stalls with `CNT_W` = 16 → `stall_count` saturates at 0xFFFF.
